// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcodes, ALU control codes, sequencer state
// encoding and the opcode-to-ALU map used by the sequencer, datapath and ALU.
package cpu_defs;

  typedef enum logic [2:0] {
    FETCH0 = 3'd0,
    FETCH1 = 3'd1,
    FETCH2 = 3'd2,
    EXEC3  = 3'd3,
    EXEC4  = 3'd4,
    EXEC5  = 3'd5,
    PAUSE  = 3'd6,
    HALT   = 3'd7
  } seq_state_e;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [4:0] ALU_NOP = 5'b00000;
  localparam logic [4:0] ALU_AND = 5'b00001;
  localparam logic [4:0] ALU_OR  = 5'b00010;
  localparam logic [4:0] ALU_ADD = 5'b00011;
  localparam logic [4:0] ALU_SUB = 5'b00100;

  // Every control output of the sequencer, in one bundle so reset can clear it at once.
  typedef struct packed {
    logic       PCout;
    logic       MARin;
    logic       IncrementPC;
    logic       Zin;
    logic       ZLOout;
    logic       PCin;
    logic       Read;
    logic       MDRin;
    logic       MDRout;
    logic       IRin;
    logic       Yin;
    logic       Rout;
    logic       Rin;
    logic       Gra;
    logic       Grb;
    logic       Grc;
    logic [4:0] ALUControl;
    logic       Run;
    logic       IllegalOp;
  } seq_ctl_t;

  function automatic logic is_alu_op(input logic [4:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
  endfunction

  function automatic logic [4:0] alu_ctrl(input logic [4:0] op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      default: return ALU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer <-> datapath bundle: instruction/memory status in, datapath strobes out.
interface control_sequencer_if;
  logic [31:0] IR;
  logic        MemReady;
  logic        Stop;
  logic        PCout, MARin, IncrementPC, Zin, ZLOout, PCin, Read, MDRin;
  logic        MDRout, IRin, Yin, Rout, Rin, Gra, Grb, Grc;
  logic [4:0]  ALUControl;
  logic        Run;
  logic        IllegalOp;

  modport master (
    input  IR, MemReady, Stop,
    output PCout, MARin, IncrementPC, Zin, ZLOout, PCin, Read, MDRin,
           MDRout, IRin, Yin, Rout, Rin, Gra, Grb, Grc, ALUControl, Run, IllegalOp
  );

  modport slave (
    output IR, MemReady, Stop,
    input  PCout, MARin, IncrementPC, Zin, ZLOout, PCin, Read, MDRin,
           MDRout, IRin, Yin, Rout, Rin, Gra, Grb, Grc, ALUControl, Run, IllegalOp
  );
endinterface

// File: rtl/control_sequencer.sv
// Moore fetch/execute sequencer for a single-bus datapath; PCin alone also
// looks at MemReady so the PC reload lands on the cycle memory data arrives.
module control_sequencer
  import cpu_defs::*;
(
  input  logic                       Clock,
  input  logic                       Resetn,
  control_sequencer_if.master        bus
);

  seq_state_e state_q, state_d;
  seq_ctl_t   ctl, ctl_out;
  logic [4:0] op;
  logic       unused_ir;

  assign op        = bus.IR[31:27];
  assign unused_ir = ^bus.IR[26:0];

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state_q <= FETCH0;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ctl     = '0;
    case (state_q)
      FETCH0: begin
        ctl.Run         = 1'b1;
        ctl.PCout       = 1'b1;
        ctl.MARin       = 1'b1;
        ctl.IncrementPC = 1'b1;
        ctl.Zin         = 1'b1;
        state_d         = FETCH1;
      end
      FETCH1: begin
        ctl.Run    = 1'b1;
        ctl.ZLOout = 1'b1;
        ctl.Read   = 1'b1;
        ctl.MDRin  = 1'b1;
        if (bus.MemReady) begin
          ctl.PCin = 1'b1;
          state_d  = FETCH2;
        end
      end
      FETCH2: begin
        ctl.Run    = 1'b1;
        ctl.MDRout = 1'b1;
        ctl.IRin   = 1'b1;
        state_d    = EXEC3;
      end
      EXEC3: begin
        ctl.Run = 1'b1;
        if (is_alu_op(op)) begin
          ctl.Grb  = 1'b1;
          ctl.Rout = 1'b1;
          ctl.Yin  = 1'b1;
          state_d  = EXEC4;
        end else if (op == OP_HALT) begin
          state_d = HALT;
        end else begin
          ctl.IllegalOp = 1'b1;
          state_d       = FETCH0;
        end
      end
      EXEC4: begin
        ctl.Run        = 1'b1;
        ctl.Grc        = 1'b1;
        ctl.Rout       = 1'b1;
        ctl.Zin        = 1'b1;
        ctl.ALUControl = alu_ctrl(op);
        state_d        = EXEC5;
      end
      EXEC5: begin
        ctl.Run    = 1'b1;
        ctl.ZLOout = 1'b1;
        ctl.Gra    = 1'b1;
        ctl.Rin    = 1'b1;
        state_d    = bus.Stop ? PAUSE : FETCH0;
      end
      PAUSE:   state_d = bus.Stop ? PAUSE : FETCH0;
      HALT:    state_d = HALT;
      default: state_d = FETCH0;
    endcase
  end

  // Reset clears outputs combinationally so strobes drop without waiting for a clock.
  assign ctl_out = Resetn ? ctl : '0;

  assign bus.PCout       = ctl_out.PCout;
  assign bus.MARin       = ctl_out.MARin;
  assign bus.IncrementPC = ctl_out.IncrementPC;
  assign bus.Zin         = ctl_out.Zin;
  assign bus.ZLOout      = ctl_out.ZLOout;
  assign bus.PCin        = ctl_out.PCin;
  assign bus.Read        = ctl_out.Read;
  assign bus.MDRin       = ctl_out.MDRin;
  assign bus.MDRout      = ctl_out.MDRout;
  assign bus.IRin        = ctl_out.IRin;
  assign bus.Yin         = ctl_out.Yin;
  assign bus.Rout        = ctl_out.Rout;
  assign bus.Rin         = ctl_out.Rin;
  assign bus.Gra         = ctl_out.Gra;
  assign bus.Grb         = ctl_out.Grb;
  assign bus.Grc         = ctl_out.Grc;
  assign bus.ALUControl  = ctl_out.ALUControl;
  assign bus.Run         = ctl_out.Run;
  assign bus.IllegalOp   = ctl_out.IllegalOp;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: strobe sequences per state, memory wait,
// halt, illegal opcode, stop/pause and asynchronous reset behaviour.
module tb_control_sequencer;

  logic Clock = 1'b0;
  logic Resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;

  control_sequencer_if bus();

  control_sequencer dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  always #5 Clock = ~Clock;

  // Strobe order: PCout MARin IncrementPC Zin ZLOout PCin Read MDRin MDRout IRin Yin Rout Rin Gra Grb Grc
  localparam logic [15:0] S_F0   = 16'hF000;
  localparam logic [15:0] S_F1W  = 16'h0B00;
  localparam logic [15:0] S_F1R  = 16'h0F00;
  localparam logic [15:0] S_F2   = 16'h00C0;
  localparam logic [15:0] S_E3   = 16'h0032;
  localparam logic [15:0] S_E4   = 16'h1011;
  localparam logic [15:0] S_E5   = 16'h080C;
  localparam logic [15:0] S_NONE = 16'h0000;

  function automatic logic [15:0] strobes();
    return {bus.PCout, bus.MARin, bus.IncrementPC, bus.Zin, bus.ZLOout, bus.PCin,
            bus.Read, bus.MDRin, bus.MDRout, bus.IRin, bus.Yin, bus.Rout,
            bus.Rin, bus.Gra, bus.Grb, bus.Grc};
  endfunction

  // Hold reset two cycles and release mid-cycle; returns inside the first FETCH0 cycle.
  task automatic do_reset(input logic [31:0] ir, input logic mr);
    Resetn = 1'b0;
    bus.IR = ir;
    bus.MemReady = mr;
    bus.Stop = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Resetn = 1'b1;
    #1;
  endtask

  task automatic step();
    @(negedge Clock);
    #1;
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    bus.IR = 32'h18000000;
    bus.MemReady = 1'b1;
    bus.Stop = 1'b0;
    #1;
    checks++;
    if (strobes() !== S_NONE || bus.ALUControl !== 5'd0 || bus.Run !== 1'b0 || bus.IllegalOp !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: strobes=%h alu=%b run=%b ill=%b, want 0000/00000/0/0",
               strobes(), bus.ALUControl, bus.Run, bus.IllegalOp);
    end
    repeat (3) @(posedge Clock);
    #1;
    checks++;
    if (strobes() !== S_NONE || bus.Run !== 1'b0) begin
      errors++;
      $display("FAIL reset_held: strobes=%h run=%b, want 0000/0", strobes(), bus.Run);
    end
    @(negedge Clock);
    Resetn = 1'b1;
    #1;
    checks++;
    if (strobes() !== S_F0 || bus.Run !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_fetch0: strobes=%h run=%b, want %h/1", strobes(), bus.Run, S_F0);
    end
  endtask

  task automatic test_and_instr();
    logic [15:0] exp_s [6] = '{S_F0, S_F1R, S_F2, S_E3, S_E4, S_E5};
    do_reset(32'h28918000, 1'b1);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      checks++;
      if (strobes() !== exp_s[c] || bus.ALUControl !== ((c == 4) ? 5'b00001 : 5'b00000) ||
          bus.Run !== 1'b1 || bus.IllegalOp !== 1'b0) begin
        errors++;
        $display("FAIL and_cycle%0d: strobes=%h alu=%b run=%b ill=%b, want %h/%b/1/0", c + 1,
                 strobes(), bus.ALUControl, bus.Run, bus.IllegalOp, exp_s[c],
                 (c == 4) ? 5'b00001 : 5'b00000);
      end
    end
    step();
    checks++;
    if (strobes() !== S_F0 || bus.Run !== 1'b1) begin
      errors++;
      $display("FAIL and_next_fetch: strobes=%h run=%b, want %h/1", strobes(), bus.Run, S_F0);
    end
  endtask

  task automatic test_alu_ops();
    logic [31:0] irs  [3] = '{32'h18000000, 32'h20000000, 32'h30000000};
    logic [4:0]  alus [3] = '{5'b00011, 5'b00100, 5'b00010};
    for (int k = 0; k < 3; k++) begin
      do_reset(irs[k], 1'b1);
      repeat (3) step();
      checks++;
      if (strobes() !== S_E3 || bus.ALUControl !== 5'd0) begin
        errors++;
        $display("FAIL alu%0d_exec3: strobes=%h alu=%b, want %h/00000", k, strobes(), bus.ALUControl, S_E3);
      end
      step();
      checks++;
      if (strobes() !== S_E4 || bus.ALUControl !== alus[k]) begin
        errors++;
        $display("FAIL alu%0d_exec4: strobes=%h alu=%b, want %h/%b", k, strobes(), bus.ALUControl, S_E4, alus[k]);
      end
    end
  endtask

  task automatic test_mem_wait();
    logic [15:0] exp_s [6] = '{S_F0, S_F1W, S_F1W, S_F1W, S_F1R, S_F2};
    logic        mr    [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    do_reset(32'h28918000, 1'b0);
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(negedge Clock);
        bus.MemReady = mr[c];
        #1;
      end
      checks++;
      if (strobes() !== exp_s[c] || bus.Run !== 1'b1) begin
        errors++;
        $display("FAIL memwait_cycle%0d: strobes=%h run=%b, want %h/1", c, strobes(), bus.Run, exp_s[c]);
      end
    end
  endtask

  task automatic test_halt();
    logic [15:0] exp_s [4] = '{S_F0, S_F1R, S_F2, S_NONE};
    int bad = 0;
    do_reset(32'hD8000000, 1'b1);
    for (int c = 0; c < 4; c++) begin
      if (c > 0) step();
      checks++;
      if (strobes() !== exp_s[c] || bus.Run !== 1'b1 || bus.IllegalOp !== 1'b0) begin
        errors++;
        $display("FAIL halt_cycle%0d: strobes=%h run=%b ill=%b, want %h/1/0", c, strobes(),
                 bus.Run, bus.IllegalOp, exp_s[c]);
      end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge Clock);
      bus.Stop = c[0];
      bus.MemReady = c[1];
      #1;
      if (strobes() !== S_NONE || bus.Run !== 1'b0 || bus.ALUControl !== 5'd0 || bus.IllegalOp !== 1'b0)
        bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_hold: %0d of 20 cycles left HALT, want 0", bad);
    end
    do_reset(32'h28918000, 1'b1);
    checks++;
    if (strobes() !== S_F0 || bus.Run !== 1'b1) begin
      errors++;
      $display("FAIL halt_reset_exit: strobes=%h run=%b, want %h/1", strobes(), bus.Run, S_F0);
    end
  endtask

  task automatic test_illegal();
    int pulses = 0;
    do_reset(32'hF8000000, 1'b1);
    if (bus.IllegalOp === 1'b1) pulses++;
    repeat (2) begin
      step();
      if (bus.IllegalOp === 1'b1) pulses++;
    end
    step();
    checks++;
    if (bus.IllegalOp !== 1'b1 || strobes() !== S_NONE || bus.Run !== 1'b1) begin
      errors++;
      $display("FAIL illegal_exec3: ill=%b strobes=%h run=%b, want 1/0000/1", bus.IllegalOp, strobes(), bus.Run);
    end
    if (bus.IllegalOp === 1'b1) pulses++;
    step();
    checks++;
    if (bus.IllegalOp !== 1'b0 || strobes() !== S_F0) begin
      errors++;
      $display("FAIL illegal_then_fetch0: ill=%b strobes=%h, want 0/%h", bus.IllegalOp, strobes(), S_F0);
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL illegal_pulse_width: %0d cycles high, want 1", pulses);
    end
  endtask

  task automatic test_stop_pause();
    logic [15:0] exp_s [6] = '{S_F0, S_F1R, S_F2, S_E3, S_E4, S_E5};
    do_reset(32'h18000000, 1'b1);
    bus.Stop = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) step();
      checks++;
      if (strobes() !== exp_s[c] || bus.Run !== 1'b1) begin
        errors++;
        $display("FAIL stop_cycle%0d: strobes=%h run=%b, want %h/1", c, strobes(), bus.Run, exp_s[c]);
      end
    end
    repeat (2) begin
      step();
      checks++;
      if (strobes() !== S_NONE || bus.Run !== 1'b0 || bus.ALUControl !== 5'd0) begin
        errors++;
        $display("FAIL stop_pause: strobes=%h run=%b alu=%b, want 0000/0/00000", strobes(), bus.Run, bus.ALUControl);
      end
    end
    @(negedge Clock);
    bus.Stop = 1'b0;
    #1;
    checks++;
    if (strobes() !== S_NONE || bus.Run !== 1'b0) begin
      errors++;
      $display("FAIL stop_drop_cycle: strobes=%h run=%b, want 0000/0", strobes(), bus.Run);
    end
    step();
    checks++;
    if (strobes() !== S_F0 || bus.Run !== 1'b1) begin
      errors++;
      $display("FAIL stop_resume: strobes=%h run=%b, want %h/1", strobes(), bus.Run, S_F0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset(32'h18000000, 1'b1);
    repeat (4) step();
    checks++;
    if (strobes() !== S_E4 || bus.ALUControl !== 5'b00011) begin
      errors++;
      $display("FAIL midrst_exec4: strobes=%h alu=%b, want %h/00011", strobes(), bus.ALUControl, S_E4);
    end
    #1;
    Resetn = 1'b0;
    #1;
    checks++;
    if (strobes() !== S_NONE || bus.ALUControl !== 5'd0 || bus.Run !== 1'b0 || bus.IllegalOp !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async_clear: strobes=%h alu=%b run=%b, want 0000/00000/0", strobes(), bus.ALUControl, bus.Run);
    end
    step();
    Resetn = 1'b1;
    #1;
    checks++;
    if (strobes() !== S_F0 || bus.Run !== 1'b1) begin
      errors++;
      $display("FAIL midrst_resume: strobes=%h run=%b, want %h/1", strobes(), bus.Run, S_F0);
    end
    step();
    checks++;
    if (strobes() !== S_F1R) begin
      errors++;
      $display("FAIL midrst_progress: strobes=%h, want %h", strobes(), S_F1R);
    end
    // Reset while stalled on memory must not let the late MemReady produce a PCin.
    do_reset(32'h18000000, 1'b0);
    step();
    Resetn = 1'b0;
    #1;
    checks++;
    if (strobes() !== S_NONE || bus.Run !== 1'b0) begin
      errors++;
      $display("FAIL fetch1rst_clear: strobes=%h run=%b, want 0000/0", strobes(), bus.Run);
    end
    @(negedge Clock);
    bus.MemReady = 1'b1;
    #1;
    checks++;
    if (strobes() !== S_NONE) begin
      errors++;
      $display("FAIL fetch1rst_no_pcin: strobes=%h, want 0000", strobes());
    end
    Resetn = 1'b1;
    #1;
    checks++;
    if (strobes() !== S_F0 || bus.Run !== 1'b1) begin
      errors++;
      $display("FAIL fetch1rst_resume: strobes=%h run=%b, want %h/1", strobes(), bus.Run, S_F0);
    end
  endtask

  initial begin
    bus.IR = 32'h0;
    bus.MemReady = 1'b0;
    bus.Stop = 1'b0;
    test_reset();
    test_and_instr();
    test_alu_ops();
    test_mem_wait();
    test_halt();
    test_illegal();
    test_stop_pause();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have port Clock, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port Resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port IR, input, 32, instruction register contents: opcode IR[31:27]; Ra/Rb/Rc select fields are decoded externally via Gra/Grb/Grc.
REQ-004 SHALL have port MemReady, input, 1, memory read data valid this cycle.
REQ-005 SHALL have port Stop, input, 1, request to pause at the next instruction boundary.
REQ-006 SHALL have outputs PCout, MARin, IncrementPC, Zin, ZLOout, PCin, Read, MDRin, MDRout, IRin, Yin, Rout, Rin, Gra, Grb, Grc, each 1 bit, datapath strobes.
REQ-007 SHALL have output ALUControl, 5 bits, ALU operation select.
REQ-008 SHALL have output Run, 1 bit, high while sequencing instructions.
REQ-009 SHALL have output IllegalOp, 1 bit, one-cycle pulse on an undefined opcode.

Function
REQ-010 SHALL be a Moore FSM with states FETCH0, FETCH1, FETCH2, EXEC3, EXEC4, EXEC5, PAUSE, HALT; all strobes decode from state only, except PCin, which also depends on MemReady.
REQ-011 FETCH0 SHALL assert PCout, MARin, IncrementPC, Zin; next state FETCH1.
REQ-012 FETCH1 SHALL assert ZLOout, Read, MDRin; stay in FETCH1 while MemReady=0; on MemReady=1 assert PCin that cycle and go to FETCH2.
REQ-013 FETCH2 SHALL assert MDRout, IRin; next state EXEC3.
REQ-014 EXEC3 SHALL decode IR[31:27] as follows.
- ALU ops go to EXEC4 with Grb, Rout, Yin asserted.
- 11011 (halt) goes to HALT with no strobes.
- Any other opcode pulses IllegalOp and returns to FETCH0.
REQ-015 ALU opcode map: 00011 add -> ALUControl 00011; 00100 sub -> 00100; 00101 and -> 00001; 00110 or -> 00010.
REQ-016 EXEC4 SHALL assert Grc, Rout, Zin, and ALUControl per REQ-015; next state EXEC5.
REQ-017 EXEC5 SHALL assert ZLOout, Gra, Rin; next state FETCH0, or PAUSE if Stop=1.
REQ-018 ALUControl SHALL be 00000 in every state except EXEC4.
REQ-019 PAUSE SHALL assert no strobes and hold Run=0; on Stop=0 go to FETCH0.
REQ-020 HALT SHALL assert no strobes, hold Run=0, and leave only via reset.
REQ-021 Run SHALL be 1 in FETCH0 through EXEC5 and 0 in PAUSE, HALT, and while Resetn=0.
REQ-022 At most one of PCout, ZLOout, MDRout, Rout SHALL be high in any cycle.
REQ-023 Stop SHALL be ignored outside EXEC5 and PAUSE; an instruction in progress always completes.

Reset
REQ-024 Resetn=0 SHALL immediately force state to FETCH0, all strobes and IllegalOp to 0, ALUControl to 00000, and Run to 0, regardless of Clock.
REQ-025 After Resetn deasserts, the first rising edge SHALL be spent in FETCH0 with its strobes active and Run=1.
REQ-026 Reset asserted mid-instruction, including while waiting in FETCH1, SHALL abandon the instruction with no further strobes.

Structure
REQ-027 The opcode constants, ALUControl codes, and state encoding SHALL live in a shared package cpu_defs shared with the datapath and ALU.
REQ-028 The block SHALL be a single module with no sub-modules; the opcode-to-ALUControl map is a combinational function in cpu_defs.

Verification
REQ-029 With IR=0x28918000 (and, opcode 00101) and MemReady tied 1, the bench SHALL see strobes FETCH0..EXEC5 in 6 cycles, with ALUControl=00001 only in cycle 5.
REQ-030 With MemReady held 0 for 3 cycles, the bench SHALL see FETCH1 held 4 cycles and PCin high only in the fourth.
REQ-031 With IR opcode 11011, the bench SHALL see HALT entered after EXEC3, Run=0, and the state held for 20 cycles until Resetn pulse.
REQ-032 With IR opcode 11111, the bench SHALL see IllegalOp high for exactly 1 cycle and then FETCH0.
REQ-033 With Stop=1 during EXEC5 of an add (00011), the bench SHALL see PAUSE, Run=0, and FETCH0 one cycle after Stop drops.
REQ-034 With Resetn pulled low mid-cycle in EXEC4, the bench SHALL see outputs zeroed before the next edge and FETCH0 resumed after release.
